// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU requests in a small FIFO, issues them one at a
// time to an external combinational ALU, and captures each result for an
// in-order valid/ready consumer.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | nothing in flight; waiting for a queued request
// DRIVE | operands on the ALU inputs; ALU outputs settling
// HOLD  | result captured; out_valid high until out_ready
module alu_op_sequencer #(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W:0]   alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_result,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_negative,
  output logic [AW:0]       count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic [SEL_W-1:0]  mem_sel [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic [DATA_W:0]   res_q;
  logic              carry_q, zero_q, neg_q;

  // Full check uses the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;

  // Next-state and pop decision; a pop always coincides with entering DRIVE.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]   <= in_a;
      mem_b[wr_ptr_q]   <= in_b;
      mem_sel[wr_ptr_q] <= in_sel;
    end
  end

  // Operand registers change only when an entry is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
    end else if (pop) begin
      alu_a_q   <= mem_a[rd_ptr_q];
      alu_b_q   <= mem_b[rd_ptr_q];
      alu_sel_q <= mem_sel[rd_ptr_q];
    end
  end

  // Capture the settled ALU outputs at the end of DRIVE; held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (state_q == DRIVE) begin
      res_q   <= alu_result;
      carry_q <= alu_carry;
      zero_q  <= alu_zero;
      neg_q   <= alu_negative;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign out_valid    = (state_q == HOLD);
  assign out_result   = res_q;
  assign out_carry    = carry_q;
  assign out_zero     = zero_q;
  assign out_negative = neg_q;
  assign count        = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a small behavioural ALU and a queue-based
// model of the request/result flow.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0;
  logic [2:0] in_sel = '0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [4:0] alu_result;
  logic       alu_carry, alu_zero, alu_negative;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_result;
  logic       out_carry, out_zero, out_negative;
  logic [2:0] count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(4), .AW(2), .DATA_W(4), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero), .out_negative(out_negative),
    .count(count)
  );

  // Behavioural ALU: carry is bit 4, zero/negative from the low nibble.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] sel);
    case (sel)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {2'b00, a[3:1]};
    endcase
  endfunction

  assign alu_result   = alu_f(alu_a, alu_b, alu_sel);
  assign alu_carry    = alu_result[4];
  assign alu_zero     = (alu_result[3:0] == 4'd0);
  assign alu_negative = alu_result[3];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [4:0] res;
    logic       c;
    logic       z;
    logic       n;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
  } req_t;

  vec_t tbl[10];
  req_t sb[$];
  bit   m_inflight, m_resv;
  bit   last_push;
  int   passed = 0, total = 0;
  int   cyc = 0;
  logic [4:0] got_res[16];
  logic       got_c[16], got_z[16], got_n[16];
  int         got_cyc[16];
  int         got_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    sb.delete();
    m_inflight = 1'b0;
    m_resv     = 1'b0;
  endtask

  // One clock: called just after a negedge with inputs applied; checks the
  // model against the DUT, advances the model across the rising edge, then
  // returns on the following negedge.
  task automatic cycle();
    int   queued;
    bit   m_in_ready, hs, issue;
    logic [4:0] exp_r;
    #1;
    last_push = 1'b0;
    if (rst_n) begin
      queued     = sb.size() - int'(m_inflight);
      m_in_ready = (queued != 4);
      check("count", 32'(count), 32'(queued));
      check("in_ready", 32'(in_ready), 32'(m_in_ready));
      check("out_valid", 32'(out_valid), 32'(m_resv));
      if (m_inflight)
        check("alu_operands", {17'b0, alu_a, alu_b, alu_sel},
              {17'b0, sb[0].a, sb[0].b, sb[0].sel});
      hs = m_resv && out_ready;
      issue = (!m_inflight || hs) && (queued > 0);
      if (hs) begin
        exp_r = alu_f(sb[0].a, sb[0].b, sb[0].sel);
        check("out_data", {24'b0, out_result, out_carry, out_zero, out_negative},
              {24'b0, exp_r, exp_r[4], exp_r[3:0] == 4'd0, exp_r[3]});
        if (got_cnt < 16) begin
          got_res[got_cnt] = out_result;
          got_c[got_cnt]   = out_carry;
          got_z[got_cnt]   = out_zero;
          got_n[got_cnt]   = out_negative;
          got_cyc[got_cnt] = cyc;
          got_cnt++;
        end
        void'(sb.pop_front());
        m_inflight = 1'b0;
        m_resv     = 1'b0;
      end else if (m_inflight && !m_resv) begin
        m_resv = 1'b1;
      end
      if (issue) m_inflight = 1'b1;
      if (in_valid && m_in_ready) begin
        sb.push_back('{a: in_a, b: in_b, sel: in_sel});
        last_push = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    in_valid = 1'b0;
    out_ready = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Push table entries first..first+n-1 as fast as they are accepted.
  task automatic feed(input int first, input int n, input int max_cyc);
    int idx = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (idx < n) begin
        in_valid = 1'b1;
        in_a = tbl[first+idx].a; in_b = tbl[first+idx].b; in_sel = tbl[first+idx].sel;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (last_push) idx++;
    end
    in_valid = 1'b0;
    check("feed_accepted", 32'(idx), 32'(n));
  endtask

  initial begin
    int acc;
    req_t p[4];

    // a=1010 b=0110, all selects; then two subtractions for flag capture.
    tbl[0] = '{4'b1010, 4'b0110, 3'd0, 5'b10000, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{4'b1010, 4'b0110, 3'd1, 5'b00100, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'b1010, 4'b0110, 3'd2, 5'b00010, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'b1010, 4'b0110, 3'd3, 5'b01110, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{4'b1010, 4'b0110, 3'd4, 5'b01100, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{4'b1010, 4'b0110, 3'd5, 5'b00101, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{4'b1010, 4'b0110, 3'd6, 5'b10100, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{4'b1010, 4'b0110, 3'd7, 5'b00101, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{4'b1010, 4'b1010, 3'd1, 5'b00000, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{4'b0010, 4'b0110, 3'd1, 5'b11100, 1'b1, 1'b0, 1'b1};

    model_reset();
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data", {7'b0, alu_a, alu_b, alu_sel, out_result, out_carry, out_zero, out_negative},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: asynchronous reset while DRIVE with three entries queued.
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_a = 4'(i + 3); in_b = 4'(i); in_sel = 3'(i);
      out_ready = (i == 5);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("t1_pre_count", 32'(count), 32'd3);
    check("t1_pre_drive", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_out_valid", 32'(out_valid), 32'd0);
    check("t1_async_count", 32'(count), 32'd0);
    check("t1_async_in_ready", 32'(in_ready), 32'd1);
    check("t1_async_data", {7'b0, alu_a, alu_b, alu_sel, out_result, out_carry, out_zero, out_negative},
          32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (out_valid) acc++;
    end
    check("t1_no_ghost_result", 32'(acc), 32'd0);

    // Test 2: single op, stalled consumer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = tbl[0].a; in_b = tbl[0].b; in_sel = tbl[0].sel;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("t2_alu_a", 32'(alu_a), 32'(4'b1010));
    check("t2_alu_b", 32'(alu_b), 32'(4'b0110));
    check("t2_alu_sel", 32'(alu_sel), 32'd0);
    check("t2_not_yet_valid", 32'(out_valid), 32'd0);
    cycle();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_result", 32'(out_result), 32'(tbl[0].res));
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t2_stall_hold", {26'b0, out_valid, out_result}, {26'b0, 1'b1, tbl[0].res});
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("t2_valid_drop", 32'(out_valid), 32'd0);
    check("t2_result_kept", 32'(out_result), 32'(tbl[0].res));
    cycle();
    check("t2_idle", 32'(out_valid), 32'd0);

    // Test 3: fill to capacity with a stalled consumer.
    do_reset();
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_a = 4'(acc + 1); in_b = 4'(15 - acc); in_sel = 3'(acc);
      cycle();
      if (last_push) acc++;
    end
    check("t3_accepted", 32'(acc), 32'd5);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cycle();
    check("t3_push_refused_on_pop", 32'(last_push), 32'd0);
    out_ready = 1'b0;
    check("t3_count_after_pop", 32'(count), 32'd3);
    cycle();
    check("t3_sixth_accepted", 32'(last_push), 32'd1);
    check("t3_count_refull", 32'(count), 32'd4);
    idle_cycles(16, 1'b1);
    check("t3_drained", 32'(sb.size()), 32'd0);

    // Test 4: streaming all selects with consumer always ready.
    do_reset();
    out_ready = 1'b1;
    got_cnt = 0;
    feed(0, 8, 12);
    idle_cycles(12, 1'b1);
    check("t4_result_count", 32'(got_cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_vec%0d", i), {24'b0, got_res[i], got_c[i], got_z[i], got_n[i]},
            {24'b0, tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].n});
      if (i > 0) check($sformatf("t4_spacing%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd2);
    end

    // Test 5: push and pop on the same edge at count=2.
    do_reset();
    for (int i = 0; i < 4; i++) p[i] = '{a: 4'(3*i + 1), b: 4'(9 - i), sel: 3'(i + 2)};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = p[i].a; in_b = p[i].b; in_sel = p[i].sel;
      cycle();
    end
    check("t5_pre_count", 32'(count), 32'd2);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_a = p[3].a; in_b = p[3].b; in_sel = p[3].sel;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t5_count_same", 32'(count), 32'd2);
    check("t5_oldest_popped", {21'b0, alu_a, alu_b, alu_sel}, {21'b0, p[1].a, p[1].b, p[1].sel});
    idle_cycles(12, 1'b1);
    check("t5_drained", 32'(sb.size()), 32'd0);

    // Test 6: zero/negative flags on consecutive results.
    got_cnt = 0;
    out_ready = 1'b1;
    feed(8, 2, 3);
    idle_cycles(8, 1'b1);
    check("t6_result_count", 32'(got_cnt), 32'd2);
    for (int i = 0; i < 2; i++)
      check($sformatf("t6_flags%0d", i), {24'b0, got_res[i], got_c[i], got_z[i], got_n[i]},
            {24'b0, tbl[8+i].res, tbl[8+i].c, tbl[8+i].z, tbl[8+i].n});

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      in_sel    = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_cycles(16, 1'b1);
    check("rand_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
